// File: rtl/arb_mux.sv
// Registered output mux that picks one of INPUT_SIZE valid/ready channels,
// either by explicit select or round-robin, into a single output word register.
module arb_mux #(
  parameter int WORD_LEN   = 8,
  parameter int INPUT_SIZE = 4,
  parameter int SEL_LEN    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WORD_LEN*INPUT_SIZE-1:0] in_data,
  input  logic [INPUT_SIZE-1:0]          in_valid,
  output logic [INPUT_SIZE-1:0]          in_ready,
  input  logic [SEL_LEN-1:0]             sel,
  input  logic                           rr_mode,
  output logic [WORD_LEN-1:0]            out_data,
  output logic [SEL_LEN-1:0]             out_src,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int PAD_LEN = 2**SEL_LEN;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state_r;
  logic [SEL_LEN-1:0]   last_grant_r;
  logic                 load_en_s;
  logic                 found_s;
  logic [SEL_LEN-1:0]   cand_s;
  logic [SEL_LEN-1:0]   rr_idx_s;
  logic                 rr_hit_s;
  logic [WORD_LEN-1:0]  cand_word_s;
  logic [PAD_LEN-1:0]   valid_pad_s;

  assign out_valid   = (state_r == FULL);
  assign load_en_s   = !out_valid || out_ready;
  // Padding lets sel index safely even when it points past the last channel.
  assign valid_pad_s = PAD_LEN'(in_valid);

  // Candidate selection: explicit select or rotating search after last grant.
  always_comb begin
    found_s  = 1'b0;
    cand_s   = {SEL_LEN{1'b0}};
    rr_idx_s = {SEL_LEN{1'b0}};
    rr_hit_s = 1'b0;
    if (rr_mode) begin
      for (int k = 1; k <= INPUT_SIZE; k++) begin
        rr_idx_s = SEL_LEN'((int'(last_grant_r) + k) % INPUT_SIZE);
        rr_hit_s = !found_s && valid_pad_s[rr_idx_s];
        cand_s   = rr_hit_s ? rr_idx_s : cand_s;
        found_s  = found_s || rr_hit_s;
      end
    end else begin
      found_s = (int'(sel) < INPUT_SIZE) && valid_pad_s[sel];
      cand_s  = sel;
    end
  end

  // Word mux; channel 0 sits in the most significant slice of in_data.
  always_comb begin
    cand_word_s = {WORD_LEN{1'b0}};
    for (int i = 0; i < INPUT_SIZE; i++) begin
      cand_word_s = (cand_s == SEL_LEN'(i)) ?
                    in_data[WORD_LEN*(INPUT_SIZE-1-i) +: WORD_LEN] : cand_word_s;
    end
  end

  // One-hot grant, suppressed during reset and while the held word is stalled.
  always_comb begin
    in_ready = {INPUT_SIZE{1'b0}};
    for (int i = 0; i < INPUT_SIZE; i++) begin
      in_ready[i] = rst && load_en_s && found_s && (cand_s == SEL_LEN'(i));
    end
  end

  // Output register FSM: load on transfer, drain to EMPTY when nothing offered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= EMPTY;
      out_data     <= {WORD_LEN{1'b0}};
      out_src      <= {SEL_LEN{1'b0}};
      last_grant_r <= SEL_LEN'(INPUT_SIZE-1);
    end else if (load_en_s) begin
      if (found_s) begin
        state_r      <= FULL;
        out_data     <= cand_word_s;
        out_src      <= cand_s;
        last_grant_r <= cand_s;
      end else begin
        state_r      <= EMPTY;
      end
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed-vector bench for arb_mux: a 4-channel instance for the main
// behaviour and a 3-channel instance for out-of-range select and mid-stream reset.
module tb_arb_mux;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        rr_mode;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;

  logic        rst3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic        rr_mode3;
  logic [7:0]  out_data3;
  logic [1:0]  out_src3;
  logic        out_valid3;
  logic        out_ready3;

  int n_checks;
  int n_fail;

  arb_mux #(.WORD_LEN(8), .INPUT_SIZE(4), .SEL_LEN(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .rr_mode(rr_mode), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  arb_mux #(.WORD_LEN(8), .INPUT_SIZE(3), .SEL_LEN(2)) dut3 (
    .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .rr_mode(rr_mode3), .out_data(out_data3),
    .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rot_src [5];
    logic [7:0] rot_dat [5];
    logic [1:0] sp_src  [3];
    logic [7:0] sp_dat  [3];
    n_checks = 0;
    n_fail   = 0;
    rot_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rot_dat = '{8'h11, 8'h22, 8'hA5, 8'h44, 8'h11};
    sp_src  = '{2'd1, 2'd3, 2'd1};
    sp_dat  = '{8'h22, 8'h44, 8'h22};

    in_data    = {8'h11, 8'h22, 8'hA5, 8'h44};
    in_data3   = {8'hC0, 8'hC1, 8'hC2};
    rst3       = 1'b0;
    in_valid3  = 3'b111;
    sel3       = 2'd0;
    rr_mode3   = 1'b0;
    out_ready3 = 1'b1;

    // Reset with everything offered and downstream ready
    rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1; rr_mode = 1'b0; sel = 2'd0;
    #1;
    check("rst_in_ready_0", in_ready, 4'b0000);
    tick();
    check("rst_in_ready_1", in_ready, 4'b0000);
    tick();
    check("rst_in_ready_2", in_ready, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_src", out_src, 2'd0);

    // Select mode, channel 2 only
    rst = 1'b1; rr_mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    check("sel_in_ready", in_ready, 4'b0100);
    tick();
    check("sel_out_valid", out_valid, 1'b1);
    check("sel_out_data", out_data, 8'hA5);
    check("sel_out_src", out_src, 2'd2);

    // Backpressure: held word stays put even as sel changes
    out_ready = 1'b0; in_valid = 4'b1111; sel = 2'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", in_ready, 4'b0000);
      tick();
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, 8'hA5);
      check("bp_out_src", out_src, 2'd2);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 4'b0001);
    tick();
    check("bp_release_data", out_data, 8'h11);
    check("bp_release_src", out_src, 2'd0);
    check("bp_release_valid", out_valid, 1'b1);

    // Round-robin rotation from reset
    rst = 1'b0;
    tick();
    rst = 1'b1; rr_mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    check("rr_first_in_ready", in_ready, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rr_src", out_src, rot_src[c]);
      check("rr_data", out_data, rot_dat[c]);
      check("rr_valid", out_valid, 1'b1);
    end

    // Sparse round-robin from last_grant=3, channels 1 and 3
    rst = 1'b0;
    tick();
    rst = 1'b1; in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("sparse_src", out_src, sp_src[c]);
      check("sparse_data", out_data, sp_dat[c]);
    end
    in_valid = 4'b0000;
    #1;
    check("drain_in_ready", in_ready, 4'b0000);
    check("drain_still_valid", out_valid, 1'b1);
    tick();
    check("drain_out_valid", out_valid, 1'b0);
    check("drain_data_hold", out_data, 8'h22);
    check("drain_src_hold", out_src, 2'd1);

    // Three-channel instance: out-of-range select, then reset while FULL
    rst3 = 1'b1; sel3 = 2'd3; in_valid3 = 3'b111;
    #1;
    check("oor_in_ready", in_ready3, 3'b000);
    tick();
    check("oor_out_valid", out_valid3, 1'b0);
    sel3 = 2'd1;
    #1;
    check("s3_in_ready", in_ready3, 3'b010);
    tick();
    check("s3_out_valid", out_valid3, 1'b1);
    check("s3_out_data", out_data3, 8'hC1);
    check("s3_out_src", out_src3, 2'd1);
    out_ready3 = 1'b0; rst3 = 1'b0;
    #1;
    check("s3_rst_in_ready", in_ready3, 3'b000);
    tick();
    check("s3_rst_out_valid", out_valid3, 1'b0);
    check("s3_rst_out_data", out_data3, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
